// File: rtl/load_store_unit_if.sv
// Bundles the core request/response channel and the data-memory port of the load/store unit.
// The slave modport is the unit's view; master is the core/memory environment's view.
interface load_store_unit_if #(
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_err;
   logic [31:0]       resp_rdata;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-addressed requests onto a word-wide memory with 1-cycle read.
// Sub-word stores are done as read-modify-write; loads are lane-selected and extended.
module load_store_unit #(
   parameter int ADDR_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   load_store_unit_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_LD_WAIT,
      S_ST_MERGE,
      S_RESP_ERR
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [1:0]        r_off;
   logic [2:0]        r_funct3;
   logic [15:0]       r_wdata;
   logic [ADDR_W-1:0] r_addr;
   logic              r_resp_valid;
   logic              r_resp_err;
   logic [31:0]       r_resp_rdata;

   logic              w_accept;
   logic              w_err;
   logic              w_latch;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [31:0]       w_mem_wdata;
   logic              w_resp_valid_next;
   logic              w_resp_err_next;
   logic [31:0]       w_resp_rdata_next;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load_data;
   logic [31:0]       w_merged;
   logic              w_unused;

   assign w_accept = bus.req_valid && (r_state == S_IDLE);
   assign w_unused = ^{bus.req_addr[31:ADDR_W+2], bus.req_wdata[31:16]};

   always_comb begin
      w_err = 1'b0;
      if (bus.req_we) begin
         w_err = (bus.req_funct3 >= 3'd3)
               || (bus.req_funct3 == 3'd1 && bus.req_addr[0])
               || (bus.req_funct3 == 3'd2 && bus.req_addr[1:0] != 2'b00);
      end else begin
         case (bus.req_funct3)
            3'd1, 3'd5:       w_err = bus.req_addr[0];
            3'd2:             w_err = (bus.req_addr[1:0] != 2'b00);
            3'd3, 3'd6, 3'd7: w_err = 1'b1;
            default:          w_err = 1'b0;
         endcase
      end
   end

   // Lane extraction and extension for loads, using the offset latched at accept.
   always_comb begin
      w_byte = bus.mem_rdata[{r_off, 3'b000} +: 8];
      w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (r_funct3)
         3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
         3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
         3'd4:    w_load_data = {24'd0, w_byte};
         3'd5:    w_load_data = {16'd0, w_half};
         default: w_load_data = bus.mem_rdata;
      endcase
   end

   always_comb begin
      w_merged = bus.mem_rdata;
      if (r_funct3 == 3'd0) begin
         w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
      end else begin
         w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_latch           = 1'b0;
      w_mem_we          = 1'b0;
      w_mem_addr        = r_addr;
      w_mem_wdata       = bus.req_wdata;
      w_resp_valid_next = 1'b0;
      w_resp_err_next   = 1'b0;
      w_resp_rdata_next = 32'd0;
      case (r_state)
         S_IDLE: begin
            w_mem_addr = bus.req_addr[ADDR_W+1:2];
            if (w_accept) begin
               w_latch = 1'b1;
               if (w_err) begin
                  w_state_next = S_RESP_ERR;
               end else if (bus.req_we) begin
                  // Full-word stores write immediately; sub-word stores read first.
                  if (bus.req_funct3 == 3'd2) begin
                     w_mem_we          = 1'b1;
                     w_resp_valid_next = 1'b1;
                  end else begin
                     w_state_next = S_ST_MERGE;
                  end
               end else begin
                  w_state_next = S_LD_WAIT;
               end
            end
         end
         S_LD_WAIT: begin
            w_resp_valid_next = 1'b1;
            w_resp_rdata_next = w_load_data;
            w_state_next      = S_IDLE;
         end
         S_ST_MERGE: begin
            w_mem_we          = 1'b1;
            w_mem_wdata       = w_merged;
            w_resp_valid_next = 1'b1;
            w_state_next      = S_IDLE;
         end
         S_RESP_ERR: begin
            w_resp_valid_next = 1'b1;
            w_resp_err_next   = 1'b1;
            w_state_next      = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_off        <= 2'd0;
         r_funct3     <= 3'd0;
         r_wdata      <= 16'd0;
         r_addr       <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= 32'd0;
      end else begin
         r_state      <= w_state_next;
         r_resp_valid <= w_resp_valid_next;
         r_resp_err   <= w_resp_err_next;
         r_resp_rdata <= w_resp_rdata_next;
         if (w_latch) begin
            r_off    <= bus.req_addr[1:0];
            r_funct3 <= bus.req_funct3;
            r_wdata  <= bus.req_wdata[15:0];
            r_addr   <= bus.req_addr[ADDR_W+1:2];
         end
      end
   end

   // Reset must suppress a pending merge write immediately, not at the next edge.
   assign bus.mem_we     = w_mem_we & ~rst;
   assign bus.mem_addr   = w_mem_addr;
   assign bus.mem_wdata  = w_mem_wdata;
   assign bus.req_ready  = (r_state == S_IDLE);
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_err   = r_resp_err;
   assign bus.resp_rdata = r_resp_rdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a word memory model, a driver that queues expected
// responses, and a monitor that checks each response pulse against the queue.
module tb_load_store_unit;
   localparam int AW = 8;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          acc;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   load_store_unit_if #(.ADDR_W(AW)) bus ();
   load_store_unit #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [31:0] mem [0:(1<<AW)-1];
   exp_t q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int n_exp = 0;
   int n_resp = 0;
   int we_cnt = 0;
   int we_mark;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
         we_cnt <= we_cnt + 1;
      end
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (bus.resp_valid) begin
         exp_t e;
         n_resp++;
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: got err=%0b rdata=%h expected no response", bus.resp_err, bus.resp_rdata);
         end else begin
            e = q.pop_front();
            check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
            check("resp_rdata", bus.resp_rdata, e.rdata);
            check("latency", cyc - e.acc, e.lat);
            $display("resp cyc=%0d err=%0b rdata=%h (expected err=%0b rdata=%h)", cyc, bus.resp_err, bus.resp_rdata, e.err, e.rdata);
         end
      end
   end

   // Called at a negedge with the unit idle; returns just after the accept edge.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic eerr, input logic [31:0] erd,
                        input int lat, input bit push);
      exp_t e;
      check("req_ready", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      if (push) begin
         e.err = eerr; e.rdata = erd; e.acc = cyc; e.lat = lat;
         q.push_back(e);
         n_exp++;
      end
      $display("req cyc=%0d we=%0b f3=%0d addr=%h wdata=%h", cyc, we, f3, a, wd);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic wait_resp();
      int i = 0;
      @(negedge clk);
      while (n_resp < n_exp && i < 20) begin
         @(negedge clk);
         i++;
      end
      if (n_resp < n_exp) begin
         total++;
         bad++;
         $display("FAIL resp_timeout: got %0d responses expected %0d", n_resp, n_exp);
         n_resp = n_exp;
      end
   endtask

   task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic eerr, input logic [31:0] erd,
                      input int lat, input int we_exp);
      we_mark = we_cnt;
      issue(we, f3, a, wd, eerr, erd, lat, 1'b1);
      wait_resp();
      check("mem_we_pulses", we_cnt - we_mark, we_exp);
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
      bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      txn(1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1, 1);
      txn(0, 3'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF, 2, 0);
      txn(0, 3'd0, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 2, 0);
      txn(0, 3'd4, 32'h13, 32'h0, 0, 32'h000000DE, 2, 0);
      txn(0, 3'd1, 32'h12, 32'h0, 0, 32'hFFFFDEAD, 2, 0);
      txn(0, 3'd5, 32'h10, 32'h0, 0, 32'h0000BEEF, 2, 0);
      txn(1, 3'd0, 32'h11, 32'h55, 0, 32'h0, 2, 1);
      txn(0, 3'd2, 32'h10, 32'h0, 0, 32'hDEAD55EF, 2, 0);
      txn(1, 3'd1, 32'h12, 32'h1234, 0, 32'h0, 2, 1);
      txn(0, 3'd2, 32'h10, 32'h0, 0, 32'h123455EF, 2, 0);

      txn(0, 3'd2, 32'h11, 32'h0, 1, 32'h0, 2, 0);
      txn(1, 3'd1, 32'h13, 32'hFFFF, 1, 32'h0, 2, 0);
      txn(0, 3'd3, 32'h10, 32'h0, 1, 32'h0, 2, 0);
      txn(1, 3'd4, 32'h10, 32'hFF, 1, 32'h0, 2, 0);
      txn(0, 3'd2, 32'h10, 32'h0, 0, 32'h123455EF, 2, 0);

      // Back-to-back: load issued in the response cycle of a byte store.
      issue(1, 3'd0, 32'h10, 32'hAA, 0, 32'h0, 2, 1'b1);
      for (int i = 0; i < 10 && !bus.resp_valid; i++) @(negedge clk);
      issue(0, 3'd2, 32'h10, 32'h0, 0, 32'h123455AA, 2, 1'b1);
      wait_resp();

      // Read-after-write: load accepted the cycle after a word store.
      issue(1, 3'd2, 32'h20, 32'hCAFEF00D, 0, 32'h0, 1, 1'b1);
      @(negedge clk);
      issue(0, 3'd2, 32'h20, 32'h0, 0, 32'hCAFEF00D, 2, 1'b1);
      wait_resp();

      // Reset while the merge write is pending must drop it.
      we_mark = we_cnt;
      issue(1, 3'd0, 32'h10, 32'h77, 0, 32'h0, 2, 1'b0);
      check("merge_mem_we", {31'd0, bus.mem_we}, 32'd1);
      rst = 1'b1;
      #1;
      check("rstmid_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("rstmid_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rstmid_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rstmid_we_pulses", we_cnt - we_mark, 0);
      @(negedge clk);
      txn(0, 3'd2, 32'h10, 32'h0, 0, 32'h123455AA, 2, 0);

      repeat (3) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
